// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity mode constants, tx state encoding and parity helper
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_EVEN   = 1;
  localparam int PARITY_ODD    = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PARITY_EVEN: parity_bit = p;
      PARITY_ODD:  parity_bit = ~p;
      default:     parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with show-ahead read and occupancy count
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with configurable frame format
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_BITS-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              tx_done
);

  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter value");
  end

  tx_state_t            state, state_nxt;
  logic [DW-1:0]        div;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_reg;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, bit_end, stop_end;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign bit_end  = (div == DW'(CLKS_PER_BIT - 1));
  assign stop_end = (state == ST_STOP) && bit_end && (bit_idx == BW'(STOP_BITS - 1));
  assign pop      = !fifo_empty && ((state == ST_IDLE) || stop_end);
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    tx_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pop) state_nxt = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg[0];
        if (bit_end && bit_idx == BW'(DATA_BITS - 1))
          state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx = par_reg;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        tx_done = stop_end;
        if (stop_end) state_nxt = pop ? ST_START : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // bit_idx counts data bits in DATA and stop bits in STOP; it is 0 elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        div     <= '0;
        bit_idx <= '0;
        shreg   <= fifo_dout;
        par_reg <= parity_bit(MAX_DATA_BITS'(fifo_dout), PARITY);
      end else if (state != ST_IDLE) begin
        div <= bit_end ? '0 : div + 1'b1;
        if (bit_end) begin
          if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= (bit_idx == BW'(DATA_BITS - 1)) ? '0 : bit_idx + 1'b1;
          end else if (state == ST_STOP) begin
            bit_idx <= stop_end ? '0 : bit_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - table and scoreboard bench for uart_tx_fifo over four frame formats
module tb_uart_tx_fifo;

  localparam int CPB = 16;
  localparam int NU  = 4;

  // unit 0: 8N1, unit 1: 8E1, unit 2: 8O1, unit 3: 7N2
  function automatic int db_of(input int u);
    return (u == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int u);
    return (u == 1 || u == 2) ? u : 0;
  endfunction
  function automatic int sb_of(input int u);
    return (u == 3) ? 2 : 1;
  endfunction
  function automatic int len_of(input int u);
    return CPB * (1 + db_of(u) + ((par_of(u) != 0) ? 1 : 0) + sb_of(u));
  endfunction

  logic            clk = 1'b0;
  logic            rst;
  logic [NU-1:0]   in_valid, in_ready, tx, busy, tx_done;
  logic [8:0]      in_data    [NU];
  logic [2:0]      fifo_count [NU];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (db_of(g)),
      .PARITY       (par_of(g)),
      .STOP_BITS    (sb_of(g)),
      .FIFO_DEPTH   (4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[g][db_of(g)-1:0]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .fifo_count (fifo_count[g]),
      .tx_done    (tx_done[g])
    );
  end

  typedef struct packed {
    logic [8:0] d;
    logic       p;
  } exp_t;

  typedef struct {
    int         u;
    logic [8:0] d;
    logic       p;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[10];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [8:0] mask_of(input int u, input logic [8:0] d);
    return d & ((9'h1 << db_of(u)) - 9'h1);
  endfunction

  function automatic logic model_par(input int u, input logic [8:0] d);
    logic [8:0] m;
    m = mask_of(u, d);
    if (par_of(u) == 2) return ~(^m);
    if (par_of(u) == 1) return ^m;
    return 1'b0;
  endfunction

  task automatic sb_push(input int u, input logic [8:0] d, input logic p);
    exp_t e;
    e.d = mask_of(u, d);
    e.p = p;
    sbq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input int u, input logic [8:0] d, input logic p);
    int t;
    t = 0;
    in_data[u]  = d;
    in_valid[u] = 1'b1;
    while (!in_ready[u] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", {31'd0, in_ready[u]}, 32'd1);
    @(posedge clk);
    sb_push(u, d, p);
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_start(input int u, input int budget);
    int t;
    t = 0;
    while (tx[u] !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", {31'd0, tx[u]}, 32'd0);
  endtask

  // Entered at the negedge of frame cycle 0; leaves at the negedge of the last cycle.
  task automatic rx_frame(input int u);
    exp_t       e;
    int         len, db, pos, bad, done_n, done_at;
    logic       exp_bit, got_p;
    logic [8:0] got;
    len = len_of(u);
    db  = db_of(u);
    bad = 0; done_n = 0; done_at = -1; got = '0; got_p = 1'b0;
    chk("sb_nonempty", sbq.size(), (sbq.size() == 0) ? 32'd1 : sbq.size());
    if (sbq.size() != 0) e = sbq.pop_front();
    else e = '0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      pos = i / CPB;
      if (pos == 0)                               exp_bit = 1'b0;
      else if (pos <= db)                         exp_bit = e.d[pos-1];
      else if (par_of(u) != 0 && pos == db + 1)   exp_bit = e.p;
      else                                        exp_bit = 1'b1;
      if (tx[u] !== exp_bit) bad++;
      if (i % CPB == CPB / 2) begin
        if (pos >= 1 && pos <= db) got[pos-1] = tx[u];
        if (par_of(u) != 0 && pos == db + 1) got_p = tx[u];
      end
      if (tx_done[u] !== 1'b0) begin
        done_n++;
        done_at = i;
      end
    end
    chk("frame_wave_bad_cycles", bad, 0);
    chk("rx_data", {23'd0, got}, {23'd0, e.d});
    if (par_of(u) != 0) chk("rx_parity", {31'd0, got_p}, {31'd0, e.p});
    chk("tx_done_pulses", done_n, 1);
    chk("tx_done_cycle", done_at, len - 1);
  endtask

  initial begin
    int   u, idx, t, over, quiet, sent;
    bit   acc, full_seen;
    logic [8:0] d;

    rst = 1'b1;
    in_valid = '0;
    for (int i = 0; i < NU; i++) in_data[i] = '0;

    vt[0] = '{0, 9'h055, 1'b0};
    vt[1] = '{1, 9'h007, 1'b1};
    vt[2] = '{2, 9'h000, 1'b1};
    vt[3] = '{2, 9'h003, 1'b1};
    vt[4] = '{3, 9'h07F, 1'b0};
    vt[5] = '{1, 9'h000, 1'b0};
    vt[6] = '{2, 9'h001, 1'b0};
    vt[7] = '{1, 9'h0A4, 1'b1};
    vt[8] = '{0, 9'h0C3, 1'b0};
    vt[9] = '{3, 9'h015, 1'b0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      chk("rst_tx", {31'd0, tx[i]}, 32'd1);
      chk("rst_busy", {31'd0, busy[i]}, 32'd0);
      chk("rst_count", {29'd0, fifo_count[i]}, 32'd0);
      chk("rst_done", {31'd0, tx_done[i]}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready[i]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NU; i++) chk("post_rst_in_ready", {31'd0, in_ready[i]}, 32'd1);

    // single frames from idle, one table row per frame
    for (int i = 0; i < 10; i++) begin
      u = vt[i].u;
      push_word(u, vt[i].d, vt[i].p);
      chk("latency_edge_k", {31'd0, tx[u]}, 32'd1);
      @(negedge clk);
      chk("latency_edge_k1", {31'd0, tx[u]}, 32'd0);
      rx_frame(u);
      chk("busy_last_cycle", {31'd0, busy[u]}, 32'd1);
      @(negedge clk);
      chk("busy_after_frame", {31'd0, busy[u]}, 32'd0);
      chk("tx_idle_after", {31'd0, tx[u]}, 32'd1);
    end

    // burst: A0..A5 with in_valid held, back-to-back frames
    full_seen = 1'b0;
    fork
      begin
        idx = 0; t = 0;
        while (idx < 6 && t < 2000) begin
          in_data[0]  = 9'h0A0 + 9'(idx);
          in_valid[0] = 1'b1;
          acc = in_ready[0];
          @(posedge clk);
          if (acc) begin
            sb_push(0, 9'h0A0 + 9'(idx), model_par(0, 9'h0A0 + 9'(idx)));
            idx++;
          end
          @(negedge clk);
          t++;
          if (idx == 5 && !full_seen) begin
            full_seen = 1'b1;
            chk("burst_full_in_ready", {31'd0, in_ready[0]}, 32'd0);
            chk("burst_full_count", {29'd0, fifo_count[0]}, 32'd4);
          end
        end
        in_valid[0] = 1'b0;
        chk("burst_accepted", idx, 6);
      end
      begin
        wait_start(0, 50);
        for (int f = 0; f < 6; f++) begin
          if (f > 0) begin
            @(negedge clk);
            chk("burst_no_gap", {31'd0, tx[0]}, 32'd0);
          end
          rx_frame(0);
        end
        @(negedge clk);
        chk("burst_busy_end", {31'd0, busy[0]}, 32'd0);
      end
    join

    // reset during DATA bit 3 with two words queued
    push_word(0, 9'h011, model_par(0, 9'h011));
    push_word(0, 9'h022, model_par(0, 9'h022));
    push_word(0, 9'h033, model_par(0, 9'h033));
    chk("pre_rst_count", {29'd0, fifo_count[0]}, 32'd2);
    repeat (71) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx[0]}, 32'd1);
    chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
    chk("midrst_count", {29'd0, fifo_count[0]}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready[0]}, 32'd0);
    chk("midrst_done", {31'd0, tx_done[0]}, 32'd0);
    @(negedge clk);
    chk("midrst_in_ready_hold", {31'd0, in_ready[0]}, 32'd0);
    rst = 1'b0;
    sbq.delete();
    quiet = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || tx_done[0] !== 1'b0 || busy[0] !== 1'b0) quiet++;
    end
    chk("post_rst_quiet_bad_cycles", quiet, 0);

    // random traffic against the serial decoder
    rand_done = 1'b0;
    over = 0;
    fork
      begin
        sent = 0; t = 0;
        while (sent < 40 && t < 20000) begin
          if (!in_valid[0] && $urandom_range(0, 1) == 1) begin
            in_data[0]  = 9'($urandom_range(0, 255));
            in_valid[0] = 1'b1;
          end
          acc = in_valid[0] && in_ready[0];
          d   = in_data[0];
          @(posedge clk);
          if (acc) begin
            sb_push(0, d, model_par(0, d));
            sent++;
          end
          @(negedge clk);
          t++;
          if (acc) in_valid[0] = 1'b0;
        end
        in_valid[0] = 1'b0;
        chk("rand_sent", sent, 40);
      end
      begin
        for (int f = 0; f < 40; f++) begin
          wait_start(0, 2000);
          rx_frame(0);
          @(negedge clk);
        end
        rand_done = 1'b1;
      end
      begin
        for (int i = 0; i < 30000 && !rand_done; i++) begin
          @(negedge clk);
          if (fifo_count[0] > 3'd4) over++;
        end
      end
    join
    chk("rand_count_overflow", over, 0);
    chk("rand_sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
